// File: rtl/block_mem_responder_if.sv
// block_mem_responder_if
//   Line-transfer interface between the cache (requester) and the backing
//   memory (responder). One request moves one full line.
//
//   Signals:
//     is_input_valid  requester -> responder  request present this cycle
//     addr[31:0]      requester -> responder  line address (already shifted)
//     mem_read        requester -> responder  request is a line read
//     mem_write       requester -> responder  request is a line write
//     din             requester -> responder  write data, BLOCK_SIZE*8 bits
//     is_output_valid responder -> requester  dout carries read data
//     dout            responder -> requester  read data, BLOCK_SIZE*8 bits
//     mem_ready       responder -> requester  responder can accept a request
//
//   Modports: master = requester side, slave = responder side.
interface block_mem_responder_if #(
  parameter int unsigned BLOCK_SIZE = 16
);
  logic                    is_input_valid;
  logic [31:0]             addr;
  logic                    mem_read;
  logic                    mem_write;
  logic [BLOCK_SIZE*8-1:0] din;
  logic                    is_output_valid;
  logic [BLOCK_SIZE*8-1:0] dout;
  logic                    mem_ready;

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din,
    input  is_output_valid, dout, mem_ready
  );

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din,
    output is_output_valid, dout, mem_ready
  );
endinterface

// File: rtl/block_mem_responder.sv
// block_mem_responder
//   Block-granular backing memory below the set-associative cache. Each
//   accepted request transfers one full line after a fixed service latency.
//   Read data is returned with a single-cycle is_output_valid pulse; completed
//   reads and writes are counted for performance reporting.
//
//   Parameters:
//     BLOCK_SIZE  line size in bytes (data ports are BLOCK_SIZE*8 bits)
//     NUM_BLOCKS  number of lines stored, power of two, >= 2
//     LATENCY     service cycles per request, >= 1
//
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous, active-high; clears array, counters, dout
//     bus          responder side of the line interface (slave modport)
//     read_count   completed reads since reset (wraps modulo 2^32)
//     write_count  completed writes since reset (wraps modulo 2^32)
module block_mem_responder #(
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned NUM_BLOCKS = 256,
  parameter int unsigned LATENCY    = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  block_mem_responder_if.slave  bus,
  output logic [31:0]           read_count,
  output logic [31:0]           write_count
);

  localparam int unsigned DW    = BLOCK_SIZE * 8;
  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;

  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               op_read;
  logic [DW-1:0]      din_q;
  logic [DW-1:0]      dout_q;
  logic [DW-1:0]      mem [NUM_BLOCKS];

  logic               ready;
  logic               out_valid;
  logic               accept;
  logic               finish;

  // Only one of read/write may be set; anything else is silently dropped.
  assign accept = bus.is_input_valid & ready & (bus.mem_read ^ bus.mem_write);
  // Last BUSY cycle: the transfer completes at the coming edge.
  assign finish = (state == BUSY) && (cnt == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; RESP accepts a new request exactly like IDLE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, RESP: next_state = accept ? BUSY : IDLE;
      BUSY: begin
        if (cnt == '0) begin
          next_state = op_read ? RESP : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready     = 1'b1;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        ready     = 1'b1;
        out_valid = 1'b0;
      end
      BUSY: begin
        ready     = 1'b0;
        out_valid = 1'b0;
      end
      RESP: begin
        ready     = 1'b1;
        out_valid = 1'b1;
      end
      default: begin
        ready     = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  assign bus.mem_ready       = ready;
  assign bus.is_output_valid = out_valid;
  assign bus.dout            = dout_q;

  // Request capture, latency counter, read data and counters.
  // Accept never coincides with BUSY, so capture and countdown are exclusive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      op_read     <= 1'b0;
      din_q       <= '0;
      dout_q      <= '0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (accept) begin
        cnt     <= CNT_W'(LATENCY - 1);
        idx     <= bus.addr[IDX_W-1:0];
        op_read <= bus.mem_read;
        din_q   <= bus.din;
      end else if (state == BUSY) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end else if (op_read) begin
          dout_q     <= mem[idx];
          read_count <= read_count + 32'd1;
        end else begin
          write_count <= write_count + 32'd1;
        end
      end
    end
  end

  // Line array; reset clears every line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        mem[i] <= '0;
      end
    end else if (finish && !op_read) begin
      mem[idx] <= din_q;
    end
  end

endmodule
